// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction ROM port, downstream stall/redirect
// controls, and the fetched-instruction / fault outputs.
//   master : fetch_unit side (drives imem_addr, instr*, fault*)
//   slave  : environment side (drives imem_rdata, stall, redirect_*)
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fault;
  logic [XLEN-1:0] fault_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc, fault, fault_pc,
    input  imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc, fault, fault_pc,
    output imem_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the RV32I core. Owns the PC, addresses a
// synchronous 1-cycle-latency instruction ROM and presents one instruction
// per cycle with its PC. Handles downstream stall, branch/jump redirect and
// a sticky fault on misaligned redirect targets.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : fetch_unit_if.master (ROM port, stall/redirect, instr/fault)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] hold_q;
  logic            hold_valid_q;
  logic            fault_q;
  logic [XLEN-1:0] fault_pc_q;
  logic            misaligned_c;

  assign misaligned_c = (bus.redirect_pc[1:0] != 2'b00);

  // PC sequencing, response tracking, stall hold register and fault capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
    end else if (state_q == RUN) begin
      if (bus.redirect_valid) begin
        if (misaligned_c) begin
          // PC stays put; the fault gates instr_valid from here on.
          state_q    <= FAULT;
          fault_q    <= 1'b1;
          fault_pc_q <= bus.redirect_pc;
        end else begin
          // Target is fetched now; its data shows up after one bubble.
          pc_q         <= bus.redirect_pc;
          resp_valid_q <= 1'b0;
          hold_valid_q <= 1'b0;
        end
      end else if (bus.stall) begin
        // ROM keeps re-reading pc_q, so latch the displayed word once.
        if (!hold_valid_q) begin
          hold_q       <= bus.imem_rdata;
          hold_valid_q <= 1'b1;
        end
      end else begin
        pc_q         <= pc_q + PC_STEP;
        resp_pc_q    <= pc_q;
        resp_valid_q <= 1'b1;
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = hold_valid_q ? hold_q : bus.imem_rdata;
  assign bus.instr_pc    = resp_pc_q;
  assign bus.instr_valid = resp_valid_q && (state_q == RUN);
  assign bus.fault       = fault_q;
  assign bus.fault_pc    = fault_pc_q;
endmodule
